// File: rtl/cache_stats_pkg.sv
// Shared types and sizes for the cache performance-counter bank.
package cache_stats_pkg;

  // Counters backed by flops: I_HIT, I_MISS, D_HIT, D_MISS, L2_HIT, L2_MISS, CYCLES.
  localparam int NUM_CNT = 7;
  localparam int ADDR_W  = 4;

  typedef enum logic [ADDR_W-1:0] {
    I_HIT   = 4'd0,
    I_MISS  = 4'd1,
    D_HIT   = 4'd2,
    D_MISS  = 4'd3,
    L2_HIT  = 4'd4,
    L2_MISS = 4'd5,
    CYCLES  = 4'd6,
    L1_HIT  = 4'd7,
    L1_MISS = 4'd8,
    CTRL    = 4'd9
  } stat_addr_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cache_stat_counter.sv
// Single saturating event counter; a clear always beats a same-cycle increment.
module cache_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             frz,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear first, otherwise count up unless frozen or already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !frz && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_stats_reader.sv
// Cache performance-counter bank with a single-outstanding read/write/resp port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; a read or write is accepted and executed on this edge
// RESP  | stat_resp high, stat_rdata shows the value latched at accept
// DONE  | dead cycle so the requester can drop read/write; no accept
module cache_stats_reader
  import cache_stats_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_access,
  input  logic              instr_resp,
  input  logic              data_access,
  input  logic              data_resp,
  input  logic              l2_access,
  input  logic              l2_resp,
  input  logic              stat_read,
  input  logic              stat_write,
  input  logic [ADDR_W-1:0] stat_addr,
  input  logic [CNT_W-1:0]  stat_wdata,
  output logic [CNT_W-1:0]  stat_rdata,
  output logic              stat_resp
);

  state_e           state_q, state_d;
  logic             resp_q, resp_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic             frz_q, frz_d;

  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] clr;
  logic [CNT_W-1:0]   cnt [NUM_CNT];

  logic [CNT_W:0]   l1_hit_sum, l1_miss_sum;
  logic [CNT_W-1:0] l1_hit, l1_miss;
  logic [CNT_W-1:0] rd_val;

  // Only bit 0 of the write data is architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^stat_wdata[CNT_W-1:1];

  // A miss is counted per stalled cycle, not per request.
  assign inc = {1'b1,
                l2_access    & ~l2_resp,    l2_access    & l2_resp,
                data_access  & ~data_resp,  data_access  & data_resp,
                instr_access & ~instr_resp, instr_access & instr_resp};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    cache_stat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .clr   (clr[i]),
      .frz   (frz_q),
      .count (cnt[i])
    );
  end

  // L1 totals: one extra carry bit, then clamp to all-ones on overflow.
  always_comb begin
    l1_hit_sum  = {1'b0, cnt[0]} + {1'b0, cnt[2]};
    l1_miss_sum = {1'b0, cnt[1]} + {1'b0, cnt[3]};
    l1_hit      = l1_hit_sum[CNT_W]  ? '1 : l1_hit_sum[CNT_W-1:0];
    l1_miss     = l1_miss_sum[CNT_W] ? '1 : l1_miss_sum[CNT_W-1:0];
  end

  // Read decode; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    case (stat_addr_e'(stat_addr))
      I_HIT:   rd_val = cnt[0];
      I_MISS:  rd_val = cnt[1];
      D_HIT:   rd_val = cnt[2];
      D_MISS:  rd_val = cnt[3];
      L2_HIT:  rd_val = cnt[4];
      L2_MISS: rd_val = cnt[5];
      CYCLES:  rd_val = cnt[6];
      L1_HIT:  rd_val = l1_hit;
      L1_MISS: rd_val = l1_miss;
      CTRL:    rd_val = {{(CNT_W-1){1'b0}}, frz_q};
      default: rd_val = '0;
    endcase
  end

  // FSM next state: accept in IDLE, clears/CTRL take effect on the accept edge.
  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    rdata_d = '0;
    frz_d   = frz_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (stat_read || stat_write) begin
          state_d = RESP;
          resp_d  = 1'b1;
          if (stat_write) begin
            case (stat_addr_e'(stat_addr))
              I_HIT, I_MISS, D_HIT, D_MISS, L2_HIT, L2_MISS, CYCLES:
                clr[stat_addr[2:0]] = 1'b1;
              L1_HIT: begin
                clr[0] = 1'b1;
                clr[2] = 1'b1;
              end
              L1_MISS: begin
                clr[1] = 1'b1;
                clr[3] = 1'b1;
              end
              CTRL:    frz_d = stat_wdata[0];
              default: ;
            endcase
          end else begin
            rdata_d = rd_val;
          end
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM register with registered response outputs and the FREEZE bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      frz_q   <= frz_d;
    end
  end

  assign stat_resp  = resp_q;
  assign stat_rdata = rdata_q;

endmodule

// File: tb/tb_cache_stats_reader.sv
// Bench for cache_stats_reader: a 32-bit and a 4-bit instance share all inputs
// and are checked against an unbounded event-count model clamped at read time.
module tb_cache_stats_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_access, instr_resp, data_access, data_resp, l2_access, l2_resp;
  logic        stat_read, stat_write;
  logic [3:0]  stat_addr;
  logic [31:0] stat_wdata;
  logic [31:0] rdata32;
  logic        resp32;
  logic [3:0]  rdata4;
  logic        resp4;

  int errors = 0;
  int checks = 0;
  bit rand_en = 1'b0;

  // Reference model: true event counts since last clear (never clamped).
  longint     cnt_m [7];
  bit         frz_m;
  bit         pend_wr;
  logic [3:0] pend_addr;
  bit         pend_wd0;

  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  always #5 clk = ~clk;

  cache_stats_reader #(.CNT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .instr_access(instr_access), .instr_resp(instr_resp),
    .data_access(data_access), .data_resp(data_resp),
    .l2_access(l2_access), .l2_resp(l2_resp),
    .stat_read(stat_read), .stat_write(stat_write),
    .stat_addr(stat_addr), .stat_wdata(stat_wdata),
    .stat_rdata(rdata32), .stat_resp(resp32)
  );

  cache_stats_reader #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .instr_access(instr_access), .instr_resp(instr_resp),
    .data_access(data_access), .data_resp(data_resp),
    .l2_access(l2_access), .l2_resp(l2_resp),
    .stat_read(stat_read), .stat_write(stat_write),
    .stat_addr(stat_addr), .stat_wdata(stat_wdata[3:0]),
    .stat_rdata(rdata4), .stat_resp(resp4)
  );

  // Model update: events count unless frozen; a pending write then clears
  // (so clear beats same-cycle events) or loads FREEZE (old FREEZE applied above).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      frz_m   = 1'b0;
      pend_wr = 1'b0;
    end else begin
      if (!frz_m) begin
        if (instr_access) begin if (instr_resp) cnt_m[0]++; else cnt_m[1]++; end
        if (data_access)  begin if (data_resp)  cnt_m[2]++; else cnt_m[3]++; end
        if (l2_access)    begin if (l2_resp)    cnt_m[4]++; else cnt_m[5]++; end
        cnt_m[6]++;
      end
      if (pend_wr) begin
        if (pend_addr <= 4'd6) cnt_m[int'(pend_addr)] = 0;
        else if (pend_addr == 4'd7) begin cnt_m[0] = 0; cnt_m[2] = 0; end
        else if (pend_addr == 4'd8) begin cnt_m[1] = 0; cnt_m[3] = 0; end
        else if (pend_addr == 4'd9) frz_m = pend_wd0;
        pend_wr = 1'b0;
      end
    end
  end

  function automatic longint model_read(input logic [3:0] a, input longint mx);
    longint v;
    if (a <= 4'd6)       v = cnt_m[int'(a)];
    else if (a == 4'd7)  v = cnt_m[0] + cnt_m[2];
    else if (a == 4'd8)  v = cnt_m[1] + cnt_m[3];
    else if (a == 4'd9)  v = longint'(frz_m);
    else                 v = 0;
    return (v > mx) ? mx : v;
  endfunction

  // Background random cache traffic, changed just after each falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rand_en) begin
      {instr_access, instr_resp, data_access, data_resp, l2_access, l2_resp} = 6'($urandom);
    end
  end

  task automatic zero_events();
    {instr_access, instr_resp, data_access, data_resp, l2_access, l2_resp} = '0;
  endtask

  // One complete transaction; entered and left just after a falling edge with the DUT in IDLE.
  task automatic do_txn(input bit rd, input bit wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input bit one_shot_ev);
    logic [31:0] exp32;
    logic [3:0]  exp4;
    stat_read  = rd;
    stat_write = wr;
    stat_addr  = addr;
    stat_wdata = wdata;
    if (wr) begin
      exp32 = '0;
      exp4  = '0;
      pend_addr = addr;
      pend_wd0  = wdata[0];
      pend_wr   = 1'b1;
    end else begin
      exp32 = 32'(model_read(addr, MAX32));
      exp4  = 4'(model_read(addr, MAX4));
    end
    @(posedge clk);
    if (one_shot_ev) begin #1; zero_events(); end
    @(negedge clk);
    checks++; if (resp32 !== 1'b1) begin errors++; $display("FAIL resp32 a=%0d wr=%0b got=%b exp=1", addr, wr, resp32); end
    checks++; if (resp4  !== 1'b1) begin errors++; $display("FAIL resp4 a=%0d wr=%0b got=%b exp=1", addr, wr, resp4); end
    checks++; if (rdata32 !== exp32) begin errors++; $display("FAIL rdata32 a=%0d wr=%0b got=%0h exp=%0h", addr, wr, rdata32, exp32); end
    checks++; if (rdata4  !== exp4)  begin errors++; $display("FAIL rdata4 a=%0d wr=%0b got=%0h exp=%0h", addr, wr, rdata4, exp4); end
    stat_read  = 1'b0;
    stat_write = 1'b0;
    stat_addr  = 4'($urandom);
    stat_wdata = $urandom;
    @(negedge clk);
    checks++; if (resp32 !== 1'b0 || resp4 !== 1'b0) begin errors++; $display("FAIL done_resp a=%0d got=%b%b exp=00", addr, resp32, resp4); end
    checks++; if (rdata32 !== 32'd0 || rdata4 !== 4'd0) begin errors++; $display("FAIL done_rdata a=%0d got=%0h/%0h exp=0/0", addr, rdata32, rdata4); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stat_read = 1'b0; stat_write = 1'b0; stat_addr = '0; stat_wdata = '0;
    zero_events();
    repeat (3) @(negedge clk);
    checks++; if (resp32 !== 1'b0 || resp4 !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b%b exp=00", resp32, resp4); end
    checks++; if (rdata32 !== 32'd0 || rdata4 !== 4'd0) begin errors++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", rdata32, rdata4); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_txn(1'b1, 1'b0, 4'd6, '0, 1'b0);
    for (int a = 0; a < 16; a++) begin
      if (a != 6) do_txn(1'b1, 1'b0, 4'(a), '0, 1'b0);
    end
  endtask

  task automatic test_miss_hit();
    instr_access = 1'b1;
    repeat (3) @(negedge clk);
    instr_resp = 1'b1;
    @(negedge clk);
    zero_events();
    do_txn(1'b1, 1'b0, 4'd1, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd0, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd8, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd7, '0, 1'b0);
  endtask

  task automatic test_saturation();
    do_txn(1'b0, 1'b1, 4'd7, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      data_access = 1'b1; data_resp = 1'b1;
      instr_access = (i < 5); instr_resp = (i < 5);
      @(negedge clk);
    end
    zero_events();
    do_txn(1'b1, 1'b0, 4'd2, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd0, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd7, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd6, '0, 1'b0);
  endtask

  task automatic test_clear_collision();
    instr_access = 1'b1; instr_resp = 1'b0;
    do_txn(1'b0, 1'b1, 4'd1, '0, 1'b1);
    do_txn(1'b1, 1'b0, 4'd1, '0, 1'b0);
    instr_access = 1'b1;
    @(negedge clk);
    zero_events();
    do_txn(1'b1, 1'b0, 4'd1, '0, 1'b0);
    // Clearing through L1_MISS with a D miss in the same cycle.
    data_access = 1'b1;
    do_txn(1'b0, 1'b1, 4'd8, '0, 1'b1);
    do_txn(1'b1, 1'b0, 4'd3, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd8, '0, 1'b0);
  endtask

  task automatic test_freeze();
    l2_access = 1'b1;
    do_txn(1'b0, 1'b1, 4'd9, 32'h1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      l2_access = 1'b1; l2_resp = 1'($urandom);
      @(negedge clk);
    end
    zero_events();
    do_txn(1'b1, 1'b0, 4'd4, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd5, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd6, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd9, '0, 1'b0);
    do_txn(1'b0, 1'b1, 4'd6, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd6, '0, 1'b0);
    do_txn(1'b0, 1'b1, 4'd9, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 6; i++) begin
      l2_access = 1'b1; l2_resp = 1'($urandom);
      @(negedge clk);
    end
    zero_events();
    do_txn(1'b1, 1'b0, 4'd4, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd5, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd6, '0, 1'b0);
  endtask

  task automatic test_random();
    int op;
    rand_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1, 2: do_txn(1'b1, 1'b0, 4'($urandom), '0, 1'b0);
        3:       do_txn(1'b0, 1'b1, 4'($urandom), $urandom, 1'b0);
        default: do_txn(1'b1, 1'b1, 4'($urandom), $urandom, 1'b0);
      endcase
    end
    rand_en = 1'b0;
    zero_events();
    do_txn(1'b0, 1'b1, 4'd9, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd7, '0, 1'b0);
    do_txn(1'b1, 1'b0, 4'd8, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic exp_resp;
    stat_read = 1'b1; stat_write = 1'b0; stat_addr = 4'd12;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_resp = (i % 3 == 0);
      checks++; if (resp32 !== exp_resp || resp4 !== exp_resp) begin errors++; $display("FAIL b2b_resp cyc=%0d got=%b%b exp=%b", i, resp32, resp4, exp_resp); end
      checks++; if (rdata32 !== 32'd0) begin errors++; $display("FAIL b2b_rdata cyc=%0d got=%0h exp=0", i, rdata32); end
    end
    stat_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp32;
    stat_read = 1'b1; stat_write = 1'b0; stat_addr = 4'd6;
    exp32 = 32'(model_read(4'd6, MAX32));
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp32 !== 1'b1 || rdata32 !== exp32) begin errors++; $display("FAIL pre_abort got=%b/%0h exp=1/%0h", resp32, rdata32, exp32); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (resp32 !== 1'b0 || resp4 !== 1'b0) begin errors++; $display("FAIL abort_resp got=%b%b exp=00", resp32, resp4); end
    checks++; if (rdata32 !== 32'd0 || rdata4 !== 4'd0) begin errors++; $display("FAIL abort_rdata got=%0h/%0h exp=0/0", rdata32, rdata4); end
    @(negedge clk);
    stat_addr = 4'd0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp32 !== 1'b1 || resp4 !== 1'b1) begin errors++; $display("FAIL held_read_resp got=%b%b exp=11", resp32, resp4); end
    checks++; if (rdata32 !== 32'd0 || rdata4 !== 4'd0) begin errors++; $display("FAIL held_read_rdata got=%0h/%0h exp=0/0", rdata32, rdata4); end
    stat_read = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 10; a++) do_txn(1'b1, 1'b0, 4'(a), '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_hit();
    test_saturation();
    test_clear_collision();
    test_freeze();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_stats_reader.md
# cache_stats_reader

Memory-mapped performance-counter bank for the L1 instruction, L1 data and L2 caches. It counts hit and miss-cycle events from the caches' access/resp strobes. It answers CPU-side read and clear requests through a single-outstanding read/write/resp handshake, the same protocol the caches use, so stall statistics can be read by software at run time.

## Interface
- CNT_W, 32: width of every counter and of stat_rdata.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_access, instr_resp  in  1 each  L1-I request / response strobes.
- data_access, data_resp  in  1 each  L1-D request / response strobes.
- l2_access, l2_resp  in  1 each  L2 request / response strobes.
- stat_read  in  1  read request; held until stat_resp.
- stat_write  in  1  write request; held until stat_resp.
- stat_addr  in  4  register index.
- stat_wdata  in  CNT_W  write data; used only at the CTRL address.
- stat_rdata  out  CNT_W  read data; valid while stat_resp=1.
- stat_resp  out  1  one-cycle completion pulse.

## Operation
- Event rules, evaluated per cycle per cache: access&resp increments the HIT counter; access&!resp increments the MISS counter (miss cycles, not miss count); !access leaves both unchanged.
- Register map:
  - 0 I_HIT, 1 I_MISS, 2 D_HIT, 3 D_MISS, 4 L2_HIT, 5 L2_MISS, 6 CYCLES (+1 every non-frozen cycle).
  - 7 L1_HIT = I_HIT+D_HIT, 8 L1_MISS = I_MISS+D_MISS. Both are combinational and read-only; the sum is saturated to all-ones.
  - 9 CTRL: bit0 FREEZE, other bits read 0.
  - 10-15 unmapped: read 0, writes ignored, resp still given.
- All counters saturate at 2^CNT_W-1 and never wrap.
- FREEZE=1 stops all counters including CYCLES. Reads still work.
- Write to addresses 0-8 clears the addressed counter(s) to 0; wdata is ignored. Writing 7 clears I_HIT and D_HIT. Writing 8 clears I_MISS and D_MISS.
- Write to 9 loads FREEZE from wdata[0].
- If read and write are both high, the request is a write and stat_rdata is 0.
- FSM:
  - IDLE: if stat_read|stat_write, capture addr/op, perform the clear/CTRL write or latch read data, then go to RESP.
  - RESP: stat_resp=1 and stat_rdata is driven from the latch; go to DONE.
  - DONE: one dead cycle with no acceptance, which lets the requester drop read/write; return to IDLE.
- Reset values: all counters 0, FREEZE 0, state IDLE, stat_resp 0, stat_rdata 0.

## Timing
- Request seen high in IDLE at edge N: stat_resp is high during cycle N+1 only. Back-to-back throughput is one request per 3 cycles.
- Read data is a snapshot taken at edge N. It does not include events occurring on cycle N itself.
- A clear and an event on the same counter in the same cycle: the clear wins, the result is 0, and the event is lost.
- A FREEZE write takes effect from cycle N+1. Events in cycle N still count.
- stat_rdata returns to 0 outside RESP.
- rst_n asserted mid-transaction aborts immediately: no resp, counters 0. After rst_n deasserts, a request still held high is accepted as a new request.
- stat_addr and stat_wdata are ignored outside the IDLE acceptance edge.

## Structure
- cache_stats_pkg:
  - stat_addr_e enum (I_HIT..CTRL)
  - state enum {IDLE, RESP, DONE}
  - NUM_CNT=7 localparam
- Sub-module cache_stat_counter, parameterised by CNT_W:
  - inputs clk, rst_n, inc, clr, frz
  - output count
  - saturating; clr has priority over inc
  - instantiated 7 times.
- The top level holds the FSM, address decode, sum/saturate logic and the read latch.

## Test plan
- Reset, then read addr 6 after 10 idle cycles -> stat_resp exactly 1 cycle later, rdata equals elapsed non-reset cycles (about 11), all other addrs read 0.
- instr_access high for 4 cycles with instr_resp only on the 4th -> I_MISS=3, I_HIT=1; read addr 8 -> 3; read addr 7 -> 1.
- Preload D_HIT near max (CNT_W=4 build, 20 hits) -> D_HIT reads 15. L1_HIT read with I_HIT=5 -> 15 saturated.
- Write addr 1 in the same cycle as an I-cache miss cycle -> I_MISS reads 0. A subsequent miss -> 1.
- Write CTRL wdata=1, drive 10 l2 events, read 4/5/6 -> unchanged. Write CTRL=0 -> counting resumes.
- Hold stat_read high through resp, assert rst_n=0 during RESP -> resp drops at once and counters are 0. After release, the held read is served with rdata 0.
